simple_exported_class: RTL and testbench

Exported-class top that implements one method, `TimesFive`, which multiplies a 32-bit unsigned argument by five. Arguments arrive on a ready/valid input channel. Results are returned in order through a show-ahead FIFO read port. The block also reports reset/startup completion and exposes a stall-injection control port for verification throttling.

---
 rtl/simple_exported_class_pkg.sv | 16 +
 rtl/simple_exported_class_fifo.sv | 53 +++++
 rtl/simple_exported_class.sv | 106 ++++++++++
 tb/tb_simple_exported_class.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/simple_exported_class_pkg.sv
// Shared types and constants for the simple_exported_class TimesFive block.
package simple_exported_class_pkg;

    typedef logic [31:0] uint32_t;
    typedef logic [2:0]  stall_rate_t;

    localparam int unsigned TIMES_FIVE_MULT = 5;
    localparam int unsigned PIPE_STAGES     = 2;
    localparam logic [7:0]  LFSR_SEED       = 8'hA5;

    // x*5 as a shift-by-two plus the original, truncated to 32 bits.
    function automatic uint32_t times_five(input uint32_t x);
        return (x << $clog2(TIMES_FIVE_MULT - 1)) + x;
    endfunction

endpackage

// File: rtl/simple_exported_class_fifo.sv
// Parameterised show-ahead FIFO: head is valid whenever empty is low.
module simple_exported_class_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           data,
    input  logic                       pop,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A full FIFO may still take a push when the same cycle frees a slot.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/simple_exported_class.sv
// TimesFive exported-class top: startup counter, ready logic, 2-stage pipe, result FIFO.
// Optional stall injection is compiled in with SIMPLE_EXPORTED_CLASS_STALL_EN.
module simple_exported_class
    import simple_exported_class_pkg::*;
#(
    parameter int FIFO_DEPTH     = 32,
    parameter int STARTUP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rst_and_startup_done_out,
    input  logic        TimesFive_valid_in,
    input  logic [31:0] TimesFive_x_in,
    output logic        TimesFive_rdy_out,
    input  logic        TimesFive_rden_in,
    output logic        TimesFive_empty_out,
    output logic [31:0] TimesFive_result_out,
    output logic        stall_rate_supported_out,
    input  logic        stall_rate_valid_in,
    input  logic [2:0]  stall_rate_in
);
    localparam int SW = $clog2(STARTUP_CYCLES + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [SW-1:0]          startup_cnt;
    logic                   startup_done;
    logic                   startup_done_q;
    logic                   stall;
    logic                   accept;
    logic [PIPE_STAGES-1:0] pipe_valid;
    uint32_t                s1_x;
    uint32_t                s2_prod;
    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          occ_total;
    logic                   unused_full;

    assign startup_done             = (startup_cnt == SW'(STARTUP_CYCLES));
    assign rst_and_startup_done_out = startup_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            startup_cnt    <= '0;
            startup_done_q <= 1'b0;
        end else begin
            if (!startup_done) startup_cnt <= startup_cnt + 1'b1;
            startup_done_q <= startup_done;
        end
    end

`ifdef SIMPLE_EXPORTED_CLASS_STALL_EN
    logic [7:0]  lfsr;
    stall_rate_t stall_rate;

    assign stall_rate_supported_out = 1'b1;
    assign stall                    = (lfsr[2:0] < stall_rate);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr       <= LFSR_SEED;
            stall_rate <= '0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (stall_rate_valid_in) stall_rate <= stall_rate_in;
        end
    end
`else
    logic unused_stall_ports;

    assign stall_rate_supported_out = 1'b0;
    assign stall                    = 1'b0;
    assign unused_stall_ports       = ^{stall_rate_valid_in, stall_rate_in};
`endif

    // Counting in-flight stages reserves FIFO room before the result exists.
    assign occ_total = fifo_count + CW'(pipe_valid[0]) + CW'(pipe_valid[1]);
    assign TimesFive_rdy_out = startup_done_q && !stall && (occ_total < CW'(FIFO_DEPTH));
    assign accept = TimesFive_valid_in && TimesFive_rdy_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            s1_x       <= '0;
            s2_prod    <= '0;
        end else begin
            pipe_valid <= {pipe_valid[0], accept};
            if (accept)        s1_x    <= TimesFive_x_in;
            if (pipe_valid[0]) s2_prod <= times_five(s1_x);
        end
    end

    simple_exported_class_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe_valid[1]),
        .data  (s2_prod),
        .pop   (TimesFive_rden_in),
        .empty (TimesFive_empty_out),
        .full  (unused_full),
        .count (fifo_count),
        .head  (TimesFive_result_out)
    );

endmodule

// File: tb/tb_simple_exported_class.sv
// Directed self-checking bench for simple_exported_class (default 32-deep FIFO, 4 startup cycles).
module tb_simple_exported_class;

    logic        clk;
    logic        rst;
    logic        done;
    logic        valid;
    logic [31:0] x;
    logic        rdy;
    logic        rden;
    logic        empty;
    logic [31:0] result;
    logic        supported;
    logic        rate_valid;
    logic [2:0]  rate;

    int errors = 0;
    int checks = 0;

    simple_exported_class dut (
        .clk                      (clk),
        .rst                      (rst),
        .rst_and_startup_done_out (done),
        .TimesFive_valid_in       (valid),
        .TimesFive_x_in           (x),
        .TimesFive_rdy_out        (rdy),
        .TimesFive_rden_in        (rden),
        .TimesFive_empty_out      (empty),
        .TimesFive_result_out     (result),
        .stall_rate_supported_out (supported),
        .stall_rate_valid_in      (rate_valid),
        .stall_rate_in            (rate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_done();
        for (int c = 0; c < 30 && !done; c++) step();
        chk("startup_done", 32'(done), 32'd1);
    endtask

    // Sends x=0..9 while popping whenever not empty; results must be 0,5,...,45.
    task automatic run_ten(input string tag);
        logic [31:0] exp_ten [10];
        int i;
        int k;
        logic acc;
        exp_ten = '{32'd0, 32'd5, 32'd10, 32'd15, 32'd20, 32'd25, 32'd30, 32'd35, 32'd40, 32'd45};
        i = 0;
        k = 0;
        for (int c = 0; c < 400 && k < 10; c++) begin
            valid = (i < 10);
            x     = 32'(i);
            if (!empty) begin
                chk(tag, result, exp_ten[k]);
                rden = 1'b1;
                k++;
            end else begin
                rden = 1'b0;
            end
            acc = valid && rdy;
            step();
            if (acc) i++;
        end
        valid = 1'b0;
        rden  = 1'b0;
        chk({tag, "_count"}, 32'(k), 32'd10);
    endtask

    initial begin
        int accepted;
        rst        = 1'b1;
        valid      = 1'b0;
        x          = '0;
        rden       = 1'b0;
        rate_valid = 1'b0;
        rate       = '0;
        repeat (10) step();

        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_result", result, 32'd0);
`ifdef SIMPLE_EXPORTED_CLASS_STALL_EN
        chk("supported", 32'(supported), 32'd1);
`else
        chk("supported", 32'(supported), 32'd0);
`endif

        rst = 1'b0;
        wait_done();
        chk("rdy_lags_done", 32'(rdy), 32'd0);
        step();
        chk("rdy_after_done", 32'(rdy), 32'd1);

        // Pop on empty is ignored.
        rden = 1'b1;
        step();
        step();
        chk("pop_empty", 32'(empty), 32'd1);
        rden = 1'b0;

        run_ten("seq");
        step();
        chk("seq_empty", 32'(empty), 32'd1);

        // Two-edge latency plus 32-bit wrap.
        valid = 1'b1;
        x     = 32'hFFFF_FFFF;
        step();
        valid = 1'b0;
        chk("lat_n", 32'(empty), 32'd1);
        step();
        chk("lat_n1", 32'(empty), 32'd1);
        step();
        chk("lat_n2", 32'(empty), 32'd0);
        chk("wrap_ffff", result, 32'hFFFF_FFFB);
        rden = 1'b1;
        valid = 1'b1;
        x     = 32'h3333_3334;
        step();
        rden  = 1'b0;
        valid = 1'b0;
        for (int c = 0; c < 10 && empty; c++) step();
        chk("wrap_3334", result, 32'h0000_0004);
        rden = 1'b1;
        step();
        rden = 1'b0;
        chk("wrap_empty", 32'(empty), 32'd1);

        // Backpressure: no pops, 45 cycles of offers; only 32 may be taken.
        accepted = 0;
        for (int c = 0; c < 45; c++) begin
            valid = 1'b1;
            x     = 32'(1000 + accepted);
            if (rdy) accepted++;
            step();
        end
        valid = 1'b0;
        chk("bp_accepted", 32'(accepted), 32'd32);
        chk("bp_rdy_low", 32'(rdy), 32'd0);
        for (int j = 0; j < 32; j++) begin
            chk("bp_not_empty", 32'(empty), 32'd0);
            chk("bp_result", result, 32'(5000 + 5 * j));
            rden = 1'b1;
            step();
        end
        rden = 1'b0;
        chk("bp_drained", 32'(empty), 32'd1);
        chk("bp_rdy_back", 32'(rdy), 32'd1);

        // Reset with five queued results.
        for (int j = 0; j < 5; j++) begin
            valid = 1'b1;
            x     = 32'(j + 1);
            step();
        end
        valid = 1'b0;
        step();
        step();
        chk("mid_queued", 32'(empty), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_rdy", 32'(rdy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        step();
        step();
        rst = 1'b0;
        wait_done();
        step();
        valid = 1'b1;
        x     = 32'd7;
        step();
        valid = 1'b0;
        for (int c = 0; c < 10 && empty; c++) step();
        chk("mid_seven", result, 32'd35);
        rden = 1'b1;
        step();
        rden = 1'b0;
        chk("mid_only_one", 32'(empty), 32'd1);

`ifdef SIMPLE_EXPORTED_CLASS_STALL_EN
        begin
            int rdy_cycles;
            rate_valid = 1'b1;
            rate       = 3'd7;
            step();
            rate_valid = 1'b0;
            rdy_cycles = 0;
            for (int c = 0; c < 128; c++) begin
                if (rdy) rdy_cycles++;
                step();
            end
            chk("stall_duty_low", 32'(rdy_cycles >= 4), 32'd1);
            chk("stall_duty_high", 32'(rdy_cycles <= 40), 32'd1);
            run_ten("stall_seq");
            rate_valid = 1'b1;
            rate       = 3'd0;
            step();
            rate_valid = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
